// File: rtl/memory_pkg.sv
// Shared read-mode type and port-count ceiling for the symbolic memory models.
package memory_pkg;

  typedef enum logic {
    ASYNC_READ = 1'b0,
    SYNC_READ  = 1'b1
  } read_type_t;

  localparam int MAX_RD_PORTS = 8;

endpackage

// File: rtl/symbolic_mem_rd_port.sv
// One read port: compares its address against every tracked entry and returns
// the matching data (or the free miss value) plus a one-hot hit vector.
module symbolic_mem_rd_port #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_SYMBOLS = 4
) (
  input  logic [ADDR_WIDTH-1:0]             rd_addr_i,
  input  logic [NUM_SYMBOLS-1:0]            ent_valid_i,
  input  logic [NUM_SYMBOLS*ADDR_WIDTH-1:0] ent_addr_i,
  input  logic [NUM_SYMBOLS*DATA_WIDTH-1:0] ent_data_i,
  input  logic [DATA_WIDTH-1:0]             miss_data_i,
  output logic [NUM_SYMBOLS-1:0]            hit_vec_o,
  output logic                              hit_o,
  output logic [DATA_WIDTH-1:0]             data_o
);

  logic [NUM_SYMBOLS-1:0] hv;
  logic [DATA_WIDTH-1:0]  sel;

  // Valid addresses are unique, so at most one bit of hv is set and an
  // AND-OR mux is enough to select the data.
  always_comb begin
    hv  = '0;
    sel = '0;
    for (int i = 0; i < NUM_SYMBOLS; i++) begin
      hv[i] = ent_valid_i[i] && (ent_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr_i);
      sel   = sel | ({DATA_WIDTH{hv[i]}} & ent_data_i[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  assign hit_vec_o = hv;
  assign hit_o     = |hv;
  assign data_o    = (|hv) ? sel : miss_data_i;

endmodule

// File: rtl/symbolic_memory_tracker.sv
// Formal-only model of a large RAM: an age-ordered table of the last
// NUM_SYMBOLS written (addr, data) pairs served to NUM_RD_PORTS read ports.
module symbolic_memory_tracker
  import memory_pkg::*;
#(
  parameter int         DATA_WIDTH      = 32,
  parameter int         ADDR_WIDTH      = 8,
  parameter int         NUM_SYMBOLS     = 4,
  parameter int         NUM_RD_PORTS    = 2,
  parameter read_type_t MEM_TYPE        = ASYNC_READ,
  parameter bit         CONSUME_ON_READ = 1'b1,
  parameter int         OCC_W           = $clog2(NUM_SYMBOLS + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_en,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic [NUM_RD_PORTS-1:0]            rd_en,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]              miss_data,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]            rd_hit,
  output logic [NUM_RD_PORTS-1:0]            rd_valid,
  output logic [OCC_W-1:0]                   occupancy,
  output logic                               full,
  output logic                               evict_valid,
  output logic [ADDR_WIDTH-1:0]              evict_addr
);

  if (NUM_RD_PORTS > MAX_RD_PORTS || NUM_RD_PORTS < 1 || NUM_SYMBOLS < 1) begin : g_bad_cfg
    $error("symbolic_memory_tracker: NUM_RD_PORTS must be 1..MAX_RD_PORTS and NUM_SYMBOLS >= 1");
  end

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t tbl_q [NUM_SYMBOLS];
  entry_t tbl_d [NUM_SYMBOLS];
  entry_t surv  [NUM_SYMBOLS];

  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  full_q, full_d;
  logic                  evict_q, evict_d;
  logic [ADDR_WIDTH-1:0] evict_addr_q, evict_addr_d;

  logic [NUM_SYMBOLS-1:0]            ent_valid;
  logic [NUM_SYMBOLS*ADDR_WIDTH-1:0] ent_addr;
  logic [NUM_SYMBOLS*DATA_WIDTH-1:0] ent_data;

  logic [NUM_SYMBOLS-1:0]            hit_vec [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0]           port_hit;
  logic [NUM_RD_PORTS*DATA_WIDTH-1:0] port_data;

  logic [NUM_SYMBOLS-1:0] consume;
  logic [NUM_SYMBOLS-1:0] keep;
  int                     rank;
  int                     cnt;

  always_comb begin
    ent_valid = '0;
    ent_addr  = '0;
    ent_data  = '0;
    for (int i = 0; i < NUM_SYMBOLS; i++) begin
      ent_valid[i]                          = tbl_q[i].valid;
      ent_addr[i*ADDR_WIDTH +: ADDR_WIDTH]  = tbl_q[i].addr;
      ent_data[i*DATA_WIDTH +: DATA_WIDTH]  = tbl_q[i].data;
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    symbolic_mem_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_SYMBOLS(NUM_SYMBOLS)
    ) u_rd_port (
      .rd_addr_i  (rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .ent_valid_i(ent_valid),
      .ent_addr_i (ent_addr),
      .ent_data_i (ent_data),
      .miss_data_i(miss_data),
      .hit_vec_o  (hit_vec[p]),
      .hit_o      (port_hit[p]),
      .data_o     (port_data[p*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Consume and same-address write both free their slot first; survivors are
  // then packed toward index 0 in age order before the new write lands there.
  always_comb begin
    consume = '0;
    if (CONSUME_ON_READ) begin
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (rd_en[p]) consume = consume | hit_vec[p];
      end
    end

    for (int i = 0; i < NUM_SYMBOLS; i++) begin
      keep[i] = tbl_q[i].valid && !consume[i] && !(wr_en && (tbl_q[i].addr == wr_addr));
      surv[i] = '0;
    end

    rank = 0;
    for (int i = 0; i < NUM_SYMBOLS; i++) begin
      if (keep[i]) begin
        for (int j = 0; j < NUM_SYMBOLS; j++) begin
          if (j == rank) surv[j] = tbl_q[i];
        end
        rank = rank + 1;
      end
    end

    evict_d      = 1'b0;
    evict_addr_d = evict_addr_q;
    for (int i = 0; i < NUM_SYMBOLS; i++) tbl_d[i] = surv[i];

    if (wr_en) begin
      tbl_d[0].valid = 1'b1;
      tbl_d[0].addr  = wr_addr;
      tbl_d[0].data  = wr_data;
      for (int i = 1; i < NUM_SYMBOLS; i++) tbl_d[i] = surv[i-1];
      if (rank == NUM_SYMBOLS) begin
        evict_d      = 1'b1;
        evict_addr_d = surv[NUM_SYMBOLS-1].addr;
      end
    end

    cnt = 0;
    for (int i = 0; i < NUM_SYMBOLS; i++) begin
      if (tbl_d[i].valid) cnt = cnt + 1;
    end
    occ_d  = OCC_W'(cnt);
    full_d = (cnt == NUM_SYMBOLS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SYMBOLS; i++) tbl_q[i] <= '0;
      occ_q        <= '0;
      full_q       <= 1'b0;
      evict_q      <= 1'b0;
      evict_addr_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SYMBOLS; i++) tbl_q[i] <= tbl_d[i];
      occ_q        <= occ_d;
      full_q       <= full_d;
      evict_q      <= evict_d;
      evict_addr_q <= evict_addr_d;
    end
  end

  assign occupancy   = occ_q;
  assign full        = full_q;
  assign evict_valid = evict_q;
  assign evict_addr  = evict_addr_q;

  // Read handshake: rd_en[p] requests a lookup; rd_valid[p] marks the cycle in
  // which rd_data/rd_hit for that port are meaningful. There is no back-pressure.
  if (MEM_TYPE == SYNC_READ) begin : g_sync
    logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_q;
    logic [NUM_RD_PORTS-1:0]            rd_hit_q;
    logic [NUM_RD_PORTS-1:0]            rd_valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_hit_q   <= '0;
        rd_valid_q <= '0;
      end else begin
        rd_valid_q <= rd_en;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
          if (rd_en[p]) begin
            rd_data_q[p*DATA_WIDTH +: DATA_WIDTH] <= port_data[p*DATA_WIDTH +: DATA_WIDTH];
            rd_hit_q[p]                           <= port_hit[p];
          end
        end
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_hit   = rd_hit_q;
    assign rd_valid = rd_valid_q;
  end else begin : g_async
    assign rd_data  = port_data;
    assign rd_hit   = port_hit;
    assign rd_valid = rd_en;
  end

endmodule

// File: tb/tb_symbolic_memory_tracker.sv
// Bench for symbolic_memory_tracker: an ASYNC_READ and a SYNC_READ instance
// share one stimulus table; the registered reads are checked from a queue.
module tb_symbolic_memory_tracker;
  import memory_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NP = 2;
  localparam int NS = 4;
  localparam int OW = 3;
  localparam int QW = 68;
  localparam int NV = 26;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic [NP-1:0]  rd_en;
  logic [NP*AW-1:0] rd_addr;
  logic [DW-1:0]  miss_data;

  logic [NP*DW-1:0] a_rd_data, s_rd_data;
  logic [NP-1:0]    a_rd_hit, s_rd_hit, a_rd_valid, s_rd_valid;
  logic [OW-1:0]    a_occ, s_occ;
  logic             a_full, s_full, a_ev, s_ev;
  logic [AW-1:0]    a_eva, s_eva;

  always #5 clk = ~clk;

  symbolic_memory_tracker #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SYMBOLS(NS), .NUM_RD_PORTS(NP),
    .MEM_TYPE(ASYNC_READ), .CONSUME_ON_READ(1'b1)
  ) u_async (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .miss_data(miss_data),
    .rd_data(a_rd_data), .rd_hit(a_rd_hit), .rd_valid(a_rd_valid),
    .occupancy(a_occ), .full(a_full), .evict_valid(a_ev), .evict_addr(a_eva)
  );

  symbolic_memory_tracker #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SYMBOLS(NS), .NUM_RD_PORTS(NP),
    .MEM_TYPE(SYNC_READ), .CONSUME_ON_READ(1'b1)
  ) u_sync (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .miss_data(miss_data),
    .rd_data(s_rd_data), .rd_hit(s_rd_hit), .rd_valid(s_rd_valid),
    .occupancy(s_occ), .full(s_full), .evict_valid(s_ev), .evict_addr(s_eva)
  );

  // Expected columns describe what is visible before the row's clock edge:
  // read results for this row's inputs, status left by the previous rows.
  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [NP-1:0] re;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [NP-1:0] eh;
    logic [DW-1:0] ed0;
    logic [DW-1:0] ed1;
    logic [OW-1:0] occ;
    logic          full;
    logic          ev;
    logic [AW-1:0] eva;
  } vec_t;

  vec_t vecs [NV];
  int   n_vec = 0;
  int   n_err = 0;
  logic [QW-1:0] exp_q [$];

  function automatic vec_t mk(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic [NP-1:0] re, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                              input logic [NP-1:0] eh, input logic [DW-1:0] ed0, input logic [DW-1:0] ed1,
                              input logic [OW-1:0] occ, input logic full, input logic ev,
                              input logic [AW-1:0] eva);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra0 = ra0; v.ra1 = ra1;
    v.eh = eh; v.ed0 = ed0; v.ed1 = ed1; v.occ = occ; v.full = full; v.ev = ev; v.eva = eva;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_en   = '0;
    rd_addr = {8'hFF, 8'hFF};
  endtask

  initial begin
    vec_t          v;
    logic [DW-1:0] md, e0, e1;
    logic [QW-1:0] q;

    //             we wa     wd            re     ra0    ra1    eh     ed0           ed1    occ  f  ev eva
    vecs[0]  = mk(1, 8'h0A, 32'hDEADBEEF, 2'b00, 8'hFF, 8'hFF, 2'b00, 32'h0,        32'h0,  3'd0, 0, 0, 8'h00);
    vecs[1]  = mk(0, 8'h00, 32'h0,        2'b01, 8'h0A, 8'hFF, 2'b01, 32'hDEADBEEF, 32'h0,  3'd1, 0, 0, 8'h00);
    vecs[2]  = mk(0, 8'h00, 32'h0,        2'b01, 8'h0A, 8'hFF, 2'b00, 32'h0,        32'h0,  3'd0, 0, 0, 8'h00);
    vecs[3]  = mk(1, 8'h10, 32'h1,        2'b00, 8'hFF, 8'hFF, 2'b00, 32'h0,        32'h0,  3'd0, 0, 0, 8'h00);
    vecs[4]  = mk(1, 8'h10, 32'h2,        2'b00, 8'hFF, 8'hFF, 2'b00, 32'h0,        32'h0,  3'd1, 0, 0, 8'h00);
    vecs[5]  = mk(0, 8'h00, 32'h0,        2'b00, 8'h10, 8'hFF, 2'b01, 32'h2,        32'h0,  3'd1, 0, 0, 8'h00);
    vecs[6]  = mk(0, 8'h00, 32'h0,        2'b01, 8'h10, 8'hFF, 2'b01, 32'h2,        32'h0,  3'd1, 0, 0, 8'h00);
    vecs[7]  = mk(1, 8'h01, 32'h11,       2'b00, 8'hFF, 8'hFF, 2'b00, 32'h0,        32'h0,  3'd0, 0, 0, 8'h00);
    vecs[8]  = mk(1, 8'h02, 32'h12,       2'b00, 8'hFF, 8'hFF, 2'b00, 32'h0,        32'h0,  3'd1, 0, 0, 8'h00);
    vecs[9]  = mk(1, 8'h03, 32'h13,       2'b00, 8'hFF, 8'hFF, 2'b00, 32'h0,        32'h0,  3'd2, 0, 0, 8'h00);
    vecs[10] = mk(1, 8'h04, 32'h14,       2'b00, 8'hFF, 8'hFF, 2'b00, 32'h0,        32'h0,  3'd3, 0, 0, 8'h00);
    vecs[11] = mk(1, 8'h05, 32'h15,       2'b00, 8'hFF, 8'hFF, 2'b00, 32'h0,        32'h0,  3'd4, 1, 0, 8'h00);
    vecs[12] = mk(0, 8'h00, 32'h0,        2'b00, 8'h01, 8'h03, 2'b10, 32'h0,        32'h13, 3'd4, 1, 1, 8'h01);
    vecs[13] = mk(0, 8'h00, 32'h0,        2'b11, 8'h03, 8'h03, 2'b11, 32'h13,       32'h13, 3'd4, 1, 0, 8'h01);
    vecs[14] = mk(0, 8'h00, 32'h0,        2'b00, 8'h03, 8'hFF, 2'b00, 32'h0,        32'h0,  3'd3, 0, 0, 8'h01);
    vecs[15] = mk(1, 8'h07, 32'h55,       2'b00, 8'hFF, 8'hFF, 2'b00, 32'h0,        32'h0,  3'd3, 0, 0, 8'h01);
    vecs[16] = mk(1, 8'h07, 32'hAA,       2'b01, 8'h07, 8'hFF, 2'b01, 32'h55,       32'h0,  3'd4, 1, 0, 8'h01);
    vecs[17] = mk(0, 8'h00, 32'h0,        2'b11, 8'h07, 8'h02, 2'b11, 32'hAA,       32'h12, 3'd4, 1, 0, 8'h01);
    vecs[18] = mk(0, 8'h00, 32'h0,        2'b00, 8'h07, 8'h05, 2'b10, 32'h0,        32'h15, 3'd2, 0, 0, 8'h01);
    vecs[19] = mk(1, 8'h08, 32'h18,       2'b00, 8'hFF, 8'hFF, 2'b00, 32'h0,        32'h0,  3'd2, 0, 0, 8'h01);
    vecs[20] = mk(1, 8'h09, 32'h19,       2'b00, 8'hFF, 8'hFF, 2'b00, 32'h0,        32'h0,  3'd3, 0, 0, 8'h01);
    vecs[21] = mk(1, 8'h04, 32'h24,       2'b00, 8'hFF, 8'hFF, 2'b00, 32'h0,        32'h0,  3'd4, 1, 0, 8'h01);
    vecs[22] = mk(0, 8'h00, 32'h0,        2'b00, 8'h04, 8'h05, 2'b11, 32'h24,       32'h15, 3'd4, 1, 0, 8'h01);
    vecs[23] = mk(1, 8'h0C, 32'h1C,       2'b00, 8'hFF, 8'hFF, 2'b00, 32'h0,        32'h0,  3'd4, 1, 0, 8'h01);
    vecs[24] = mk(0, 8'h00, 32'h0,        2'b00, 8'h05, 8'h0C, 2'b10, 32'h0,        32'h1C, 3'd4, 1, 1, 8'h05);
    vecs[25] = mk(0, 8'h00, 32'h0,        2'b00, 8'hFF, 8'hFF, 2'b00, 32'h0,        32'h0,  3'd4, 1, 0, 8'h05);

    // Reset state
    rst = 1'b1;
    drive_idle();
    md = $urandom;
    miss_data = md;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_occ",      64'(a_occ),      64'(0));
    chk("rst_full",     64'(a_full),     64'(0));
    chk("rst_ev",       64'(a_ev),       64'(0));
    chk("rst_eva",      64'(a_eva),      64'(0));
    chk("rst_a_hit",    64'(a_rd_hit),   64'(0));
    chk("rst_a_data",   64'(a_rd_data),  {md, md});
    chk("rst_s_valid",  64'(s_rd_valid), 64'(0));
    chk("rst_s_hit",    64'(s_rd_hit),   64'(0));
    chk("rst_s_data",   64'(s_rd_data),  64'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      v  = vecs[i];
      md = $urandom;
      wr_en     = v.we;
      wr_addr   = v.wa;
      wr_data   = v.wd;
      rd_en     = v.re;
      rd_addr   = {v.ra1, v.ra0};
      miss_data = md;
      #2;
      e0 = v.eh[0] ? v.ed0 : md;
      e1 = v.eh[1] ? v.ed1 : md;
      chk($sformatf("v%0d_hit", i),   64'(a_rd_hit),   64'(v.eh));
      chk($sformatf("v%0d_data0", i), 64'(a_rd_data[DW-1:0]),  64'(e0));
      chk($sformatf("v%0d_data1", i), 64'(a_rd_data[2*DW-1:DW]), 64'(e1));
      chk($sformatf("v%0d_valid", i), 64'(a_rd_valid), 64'(v.re));
      chk($sformatf("v%0d_occ", i),   64'(a_occ),      64'(v.occ));
      chk($sformatf("v%0d_full", i),  64'(a_full),     64'(v.full));
      chk($sformatf("v%0d_ev", i),    64'(a_ev),       64'(v.ev));
      chk($sformatf("v%0d_eva", i),   64'(a_eva),      64'(v.eva));
      chk($sformatf("v%0d_s_occ", i), 64'(s_occ),      64'(v.occ));

      if (exp_q.size() > 0) begin
        q = exp_q.pop_front();
        chk($sformatf("v%0d_s_valid", i), 64'(s_rd_valid), 64'(q[67:66]));
        if (q[66]) begin
          chk($sformatf("v%0d_s_hit0", i),  64'(s_rd_hit[0]), 64'(q[64]));
          chk($sformatf("v%0d_s_data0", i), 64'(s_rd_data[DW-1:0]), 64'(q[63:32]));
        end
        if (q[67]) begin
          chk($sformatf("v%0d_s_hit1", i),  64'(s_rd_hit[1]), 64'(q[65]));
          chk($sformatf("v%0d_s_data1", i), 64'(s_rd_data[2*DW-1:DW]), 64'(q[31:0]));
        end
      end else begin
        chk($sformatf("v%0d_s_valid_idle", i), 64'(s_rd_valid), 64'(0));
      end
      if (v.re != '0) exp_q.push_back({v.re, v.eh, e0, e1});
    end

    // SYNC read result one cycle later, then reset asserted mid-read.
    @(negedge clk);
    drive_idle();
    rd_en   = 2'b01;
    rd_addr = {8'hFF, 8'h04};
    md = $urandom;
    miss_data = md;
    #2;
    chk("mid_a_hit",  64'(a_rd_hit[0]), 64'(1));
    chk("mid_a_data", 64'(a_rd_data[DW-1:0]), 64'(32'h24));
    @(posedge clk);
    #1;
    chk("mid_s_valid", 64'(s_rd_valid), 64'(2'b01));
    chk("mid_s_hit",   64'(s_rd_hit[0]), 64'(1));
    chk("mid_s_data",  64'(s_rd_data[DW-1:0]), 64'(32'h24));
    chk("mid_occ",     64'(a_occ), 64'(3));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_s_valid", 64'(s_rd_valid), 64'(0));
    chk("arst_s_hit",   64'(s_rd_hit),   64'(0));
    chk("arst_s_data",  64'(s_rd_data),  64'(0));
    chk("arst_a_occ",   64'(a_occ),      64'(0));
    chk("arst_s_occ",   64'(s_occ),      64'(0));
    chk("arst_full",    64'(a_full),     64'(0));
    chk("arst_eva",     64'(a_eva),      64'(0));
    chk("arst_a_hit",   64'(a_rd_hit),   64'(0));
    chk("arst_a_data",  64'(a_rd_data),  {md, md});
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    @(negedge clk);
    #2;
    chk("post_rst_s_valid", 64'(s_rd_valid), 64'(0));
    chk("post_rst_occ",     64'(a_occ),      64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
